// File: rtl/move_tracker_pkg.sv
// Shared encodings for move_tracker: move codes, error codes, FSM states and grid sizing.
package move_tracker_pkg;

  localparam int GRID_W  = 4;
  localparam int COUNT_W = 8;

  localparam logic [1:0] MOVE_UP    = 2'b00;
  localparam logic [1:0] MOVE_RIGHT = 2'b01;
  localparam logic [1:0] MOVE_LEFT  = 2'b10;
  localparam logic [1:0] MOVE_DOWN  = 2'b11;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_GOAL     = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;
  localparam logic [1:0] ERR_BOUNDS   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRACK,
    ST_DONE,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/move_tracker_step.sv
// Combinational single-step integrator: applies one move to (row, col) with modulo-16 wrap
// and flags moves that would leave the grid.
module move_step
  import move_tracker_pkg::*;
(
  input  logic [GRID_W-1:0] row_i,
  input  logic [GRID_W-1:0] col_i,
  input  logic [1:0]        move_i,
  output logic [GRID_W-1:0] row_o,
  output logic [GRID_W-1:0] col_o,
  output logic              offgrid_o
);

  // Natural 4-bit wrap gives the modulo behaviour; offgrid reports the edge crossing.
  always_comb begin
    row_o     = row_i;
    col_o     = col_i;
    offgrid_o = 1'b0;
    case (move_i)
      MOVE_UP: begin
        row_o     = row_i - 1'b1;
        offgrid_o = (row_i == '0);
      end
      MOVE_RIGHT: begin
        col_o     = col_i + 1'b1;
        offgrid_o = (col_i == '1);
      end
      MOVE_LEFT: begin
        col_o     = col_i - 1'b1;
        offgrid_o = (col_i == '0);
      end
      default: begin
        row_o     = row_i + 1'b1;
        offgrid_o = (row_i == '1);
      end
    endcase
  end

endmodule

// File: rtl/move_tracker.sv
// Integrates a handshaked move stream into a grid position and verifies the path ends on goal.
// Define MOVE_TRACKER_BOUNDS_CHECK_EN to reject off-grid moves instead of wrapping.
module move_tracker
  import move_tracker_pkg::*;
#(
  parameter logic [GRID_W-1:0] START_ROW = 4'd0,
  parameter logic [GRID_W-1:0] START_COL = 4'd0,
  parameter logic [GRID_W-1:0] GOAL_ROW  = 4'd15,
  parameter logic [GRID_W-1:0] GOAL_COL  = 4'd15
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic               move_valid_i,
  input  logic [1:0]         move_i,
  input  logic               move_last_i,
  output logic               move_ready_o,
  output logic [GRID_W-1:0]  row_o,
  output logic [GRID_W-1:0]  col_o,
  output logic [COUNT_W-1:0] move_count_o,
  output logic               arrived_o,
  output logic               error_o,
  output logic [1:0]         err_code_o
);

  state_e              state_q, state_d;
  logic [GRID_W-1:0]   row_q, row_d;
  logic [GRID_W-1:0]   col_q, col_d;
  logic [COUNT_W-1:0]  moveCount_q, moveCount_d;
  logic                arrived_q, arrived_d;
  logic                error_q, error_d;
  logic [1:0]          errCode_q, errCode_d;

  logic [GRID_W-1:0]   nextRow;
  logic [GRID_W-1:0]   nextCol;
  logic                offgrid;
  logic                accept;

  move_step u_step (
    .row_i     (row_q),
    .col_i     (col_q),
    .move_i    (move_i),
    .row_o     (nextRow),
    .col_o     (nextCol),
    .offgrid_o (offgrid)
  );

`ifndef MOVE_TRACKER_BOUNDS_CHECK_EN
  logic unusedOffgrid;
  assign unusedOffgrid = offgrid;
`endif

  assign accept = (state_q == ST_TRACK) && move_valid_i;

  // Start outranks the handshake, so a move offered alongside start is dropped.
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    moveCount_d = moveCount_q;
    arrived_d   = arrived_q;
    error_d     = error_q;
    errCode_d   = errCode_q;
    if (start_i) begin
      state_d     = ST_TRACK;
      row_d       = START_ROW;
      col_d       = START_COL;
      moveCount_d = '0;
      arrived_d   = 1'b0;
      error_d     = 1'b0;
      errCode_d   = ERR_NONE;
    end else if (accept) begin
      if (moveCount_q == '1) begin
        state_d   = ST_FAIL;
        error_d   = 1'b1;
        errCode_d = ERR_OVERFLOW;
      end
`ifdef MOVE_TRACKER_BOUNDS_CHECK_EN
      else if (offgrid) begin
        state_d   = ST_FAIL;
        error_d   = 1'b1;
        errCode_d = ERR_BOUNDS;
      end
`endif
      else begin
        row_d       = nextRow;
        col_d       = nextCol;
        moveCount_d = moveCount_q + 1'b1;
        if (move_last_i) begin
          if ((nextRow == GOAL_ROW) && (nextCol == GOAL_COL)) begin
            state_d   = ST_DONE;
            arrived_d = 1'b1;
          end else begin
            state_d   = ST_FAIL;
            error_d   = 1'b1;
            errCode_d = ERR_GOAL;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      row_q       <= START_ROW;
      col_q       <= START_COL;
      moveCount_q <= '0;
      arrived_q   <= 1'b0;
      error_q     <= 1'b0;
      errCode_q   <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      moveCount_q <= moveCount_d;
      arrived_q   <= arrived_d;
      error_q     <= error_d;
      errCode_q   <= errCode_d;
    end
  end

  assign move_ready_o = (state_q == ST_TRACK);
  assign row_o        = row_q;
  assign col_o        = col_q;
  assign move_count_o = moveCount_q;
  assign arrived_o    = arrived_q;
  assign error_o      = error_q;
  assign err_code_o   = errCode_q;

endmodule

// File: tb/tb_move_tracker.sv
// Self-checking bench for move_tracker: vector table plus looped long paths, checked via a scoreboard queue.
module tb_move_tracker;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] col;
    logic [7:0] cnt;
    logic       ready;
    logic       arrived;
    logic       error;
    logic [1:0] code;
  } out_t;

  typedef struct {
    logic       start;
    logic       valid;
    logic [1:0] mv;
    logic       last;
    out_t       exp;
    string      name;
  } vec_t;

  typedef struct {
    out_t  exp;
    string name;
  } sb_t;

  sb_t  sbQueue[$];
  vec_t table_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] mv    = 2'b00;
  logic       last  = 1'b0;

  logic       ready;
  logic [3:0] row;
  logic [3:0] col;
  logic [7:0] cnt;
  logic       arrived;
  logic       error;
  logic [1:0] code;
  out_t       actual;

  move_tracker dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .move_valid_i (valid),
    .move_i       (mv),
    .move_last_i  (last),
    .move_ready_o (ready),
    .row_o        (row),
    .col_o        (col),
    .move_count_o (cnt),
    .arrived_o    (arrived),
    .error_o      (error),
    .err_code_o   (code)
  );

  always #5 clk = ~clk;

  assign actual = {row, col, cnt, ready, arrived, error, code};

  function automatic out_t mk(input int r, input int c, input int n, input logic rd,
                              input logic a, input logic e, input logic [1:0] cd);
    out_t o;
    o = {4'(r), 4'(c), 8'(n), rd, a, e, cd};
    return o;
  endfunction

  task automatic compare(input string nm, input out_t exp);
    checks++;
    if (actual !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got row=%0d col=%0d cnt=%0d ready=%b arrived=%b error=%b code=%b, expected row=%0d col=%0d cnt=%0d ready=%b arrived=%b error=%b code=%b",
               nm, actual.row, actual.col, actual.cnt, actual.ready, actual.arrived, actual.error, actual.code,
               exp.row, exp.col, exp.cnt, exp.ready, exp.arrived, exp.error, exp.code);
    end
  endtask

  task automatic checkOutput();
    sb_t item;
    if (sbQueue.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
    end else begin
      item = sbQueue.pop_front();
      compare(item.name, item.exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [1:0] m, input logic l,
                               input out_t e, input string nm);
    sb_t item;
    @(negedge clk);
    start = s;
    valid = v;
    mv    = m;
    last  = l;
    item.exp  = e;
    item.name = nm;
    sbQueue.push_back(item);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic addVec(input logic s, input logic v, input logic [1:0] m, input logic l,
                        input out_t e, input string nm);
    vec_t t;
    t.start = s;
    t.valid = v;
    t.mv    = m;
    t.last  = l;
    t.exp   = e;
    t.name  = nm;
    table_q.push_back(t);
  endtask

  initial begin
    // Short paths, restarts, ignored moves and edge behaviour
    addVec(0, 1, 2'b11, 0, mk(0, 0, 0, 0, 0, 0, 2'b00), "idle_ignore");
    addVec(1, 0, 2'b00, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "start");
    addVec(0, 1, 2'b11, 0, mk(1, 0, 1, 1, 0, 0, 2'b00), "down");
    addVec(0, 1, 2'b01, 0, mk(1, 1, 2, 1, 0, 0, 2'b00), "right");
    addVec(0, 1, 2'b01, 1, mk(1, 2, 3, 0, 0, 1, 2'b01), "goal_mismatch");
    addVec(0, 1, 2'b11, 0, mk(1, 2, 3, 0, 0, 1, 2'b01), "fail_hold");
    addVec(1, 1, 2'b01, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "restart_from_fail");
    addVec(0, 1, 2'b11, 0, mk(1, 0, 1, 1, 0, 0, 2'b00), "track_move");
    addVec(1, 1, 2'b01, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "restart_in_track");
    addVec(0, 1, 2'b01, 0, mk(0, 1, 1, 1, 0, 0, 2'b00), "held_valid_1");
    addVec(0, 1, 2'b11, 0, mk(1, 1, 2, 1, 0, 0, 2'b00), "held_valid_2");
    addVec(0, 1, 2'b10, 0, mk(1, 0, 3, 1, 0, 0, 2'b00), "held_valid_3");
    addVec(0, 1, 2'b00, 0, mk(0, 0, 4, 1, 0, 0, 2'b00), "held_valid_4");
    addVec(0, 0, 2'b01, 0, mk(0, 0, 4, 1, 0, 0, 2'b00), "no_valid");
    addVec(1, 0, 2'b00, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "start_bounds");
`ifdef MOVE_TRACKER_BOUNDS_CHECK_EN
    addVec(0, 1, 2'b00, 0, mk(0, 0, 0, 0, 0, 1, 2'b11), "up_offgrid");
    addVec(0, 1, 2'b10, 0, mk(0, 0, 0, 0, 0, 1, 2'b11), "offgrid_hold");
    addVec(0, 1, 2'b11, 0, mk(0, 0, 0, 0, 0, 1, 2'b11), "offgrid_hold2");
`else
    addVec(0, 1, 2'b00, 0, mk(15, 0, 1, 1, 0, 0, 2'b00), "up_wrap");
    addVec(0, 1, 2'b10, 0, mk(15, 15, 2, 1, 0, 0, 2'b00), "left_wrap");
    addVec(0, 1, 2'b11, 0, mk(0, 15, 3, 1, 0, 0, 2'b00), "down_wrap");
`endif

    // Reset asserted between edges must clear everything immediately
    #1 rst_n = 1'b0;
    #2 compare("reset_state", mk(0, 0, 0, 0, 0, 0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < table_q.size(); i++) begin
      applyStimulus(table_q[i].start, table_q[i].valid, table_q[i].mv, table_q[i].last,
                    table_q[i].exp, table_q[i].name);
    end

    // Full path from (0,0) down the first column then across to the goal
    applyStimulus(1, 0, 2'b00, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "goal_start");
    for (int i = 1; i <= 15; i++)
      applyStimulus(0, 1, 2'b11, 0, mk(i, 0, i, 1, 0, 0, 2'b00), "goal_down");
    for (int j = 1; j <= 15; j++)
      applyStimulus(0, 1, 2'b01, (j == 15), mk(15, j, 15 + j, (j != 15), (j == 15), 0, 2'b00),
                    (j == 15) ? "goal_arrive" : "goal_right");
    applyStimulus(0, 1, 2'b10, 0, mk(15, 15, 30, 0, 1, 0, 2'b00), "done_hold");

    // 255 accepted moves, then one more offered overflows
    applyStimulus(1, 0, 2'b00, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "ovf_start");
    for (int i = 1; i <= 255; i++)
      applyStimulus(0, 1, (i % 2 == 1) ? 2'b01 : 2'b10, 0, mk(0, i % 2, i, 1, 0, 0, 2'b00), "ovf_fill");
    applyStimulus(0, 1, 2'b10, 0, mk(0, 1, 255, 0, 0, 1, 2'b10), "overflow");

    // Reset mid-path after three moves
    applyStimulus(1, 0, 2'b00, 0, mk(0, 0, 0, 1, 0, 0, 2'b00), "rst_start");
    applyStimulus(0, 1, 2'b11, 0, mk(1, 0, 1, 1, 0, 0, 2'b00), "rst_m1");
    applyStimulus(0, 1, 2'b11, 0, mk(2, 0, 2, 1, 0, 0, 2'b00), "rst_m2");
    applyStimulus(0, 1, 2'b01, 0, mk(2, 1, 3, 1, 0, 0, 2'b00), "rst_m3");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 compare("async_reset", mk(0, 0, 0, 0, 0, 0, 2'b00));
    @(posedge clk);
    #1 compare("reset_hold", mk(0, 0, 0, 0, 0, 0, 2'b00));
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 2'b01, 0, mk(0, 0, 0, 0, 0, 0, 2'b00), "post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_tracker.md
# move_tracker

Consumer-side counterpart to the maze solver's Move playback stream. It accepts the 2-bit move sequence one move per handshake, integrates it into a (row, col) position on a 16x16 grid starting from a fixed origin, and counts moves. At the last move it checks that the position equals the goal cell and reports arrival or a typed error. It sits downstream of the solver and independently verifies every path the solver replays.

## Interface
- START_ROW, 0, origin row loaded on start (0..15)
- START_COL, 0, origin column loaded on start (0..15)
- GOAL_ROW, 15, required final row
- GOAL_COL, 15, required final column
- clk  in  1  single clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- start  in  1  one-cycle pulse; loads origin, clears count, enters TRACK
- move_valid  in  1  move and move_last are valid this cycle
- move  in  2  00 up (row-1), 01 right (col+1), 10 left (col-1), 11 down (row+1)
- move_last  in  1  qualifies the final move of the path
- move_ready  out  1  high only in TRACK
- row  out  4  current row
- col  out  4  current column
- move_count  out  8  number of accepted moves
- arrived  out  1  sticky; path ended on goal
- error  out  1  sticky; path rejected
- err_code  out  2  00 none, 01 goal mismatch, 10 count overflow, 11 out of bounds

## Operation
- States: IDLE, TRACK, DONE, FAIL.
- IDLE: move_ready=0; start -> TRACK, row/col <= START_ROW/START_COL, move_count <= 0, arrived/error/err_code cleared.
- TRACK: a move is accepted on an edge with move_valid && move_ready. Position and count update on that edge.
  - move_count == 255 and another move is offered -> FAIL, err_code 10, position and count unchanged.
  - Offgrid move (row 0 up, row 15 down, col 0 left, col 15 right): see Configuration.
  - Accepted move with move_last=1: post-move position == goal -> DONE, arrived=1; otherwise FAIL, err_code 01. Count includes the last move.
- DONE/FAIL: move_ready=0; outputs hold; start -> TRACK with full reinitialisation.
- start in TRACK restarts: reinitialises and ignores any move offered in the same cycle.
- move_valid while move_ready=0 is ignored and has no effect.

## Timing
- Reset (rst=0, asynchronous): state IDLE, row=START_ROW, col=START_COL, move_count=0, move_ready=0, arrived=0, error=0, err_code=00. These values apply immediately, including mid-path. Release is sampled synchronously.
- move_ready goes high the cycle after start is sampled.
- Latency 1: the updated row/col/move_count are visible after the accepting edge. arrived/error rise after the edge that accepts the last move or detects the error. move_ready drops the cycle after.
- Throughput: one move per cycle while move_valid is held high.
- Priority: rst > start > move handshake.

## Configuration
- MOVE_TRACKER_BOUNDS_CHECK_EN defined: an offgrid move -> FAIL, err_code 11, position unchanged, move not counted.
- Undefined: row/col wrap modulo 16 (e.g. up from row 0 -> row 15). err_code 11 never produced.

## Structure
- Package move_tracker_pkg holds:
  - move encoding constants MOVE_UP/RIGHT/LEFT/DOWN
  - err_code localparams
  - state enum typedef
  - grid width constant (4)
- Sub-module move_step (combinational): takes row, col and move; returns next row, next col and an offgrid flag. The top level holds the FSM, registers and counter.

## Test plan
- Reset mid-TRACK after 3 moves -> all outputs return to their reset values at once, without waiting for a clock edge. move_ready=0.
- Origin (0,0), 15×11 then 15×01 with the last flagged -> row=15, col=15, move_count=30, arrived=1, move_ready low the next cycle.
- Origin (0,0), path 11, 01, 01 (last) -> (1,2), error=1, err_code=01, move_count=3.
- With MOVE_TRACKER_BOUNDS_CHECK_EN, first move 00 from (0,0) -> err_code=11, row=0, move_count=0. Without the macro -> row=15, tracking continues.
- 255 alternating 01/10 moves, then one more offered -> err_code=10, move_count=255.
- start pulsed while move_valid=1 in TRACK -> that move is ignored; position returns to origin, move_count=0. move_valid held high afterwards -> one move accepted per cycle.
